// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with credit-limited fetch and redirect flush
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} fetchState_t;

  fetchState_t   state, stateNext;
  logic [CW-1:0] discard, discardNext;
  logic [CW-1:0] count, outstanding, outNext;
  logic [CW:0]   occupancy;
  logic [PW-1:0] head, tail;
  logic [15:0]   fetchPc, respPc;
  logic [15:0]   dataMem [DEPTH];
  logic [15:0]   pcMem   [DEPTH];
  logic          rspAccept, pop, push, grant;

  assign mem_addr    = fetchPc;
  assign instruction = dataMem[head];
  assign instr_pc    = pcMem[head];

  // Handshakes and credit check; a response with nothing outstanding is a stray and is ignored
  always_comb begin
    rspAccept   = mem_rvalid && (outstanding != '0);
    instr_valid = (count != '0) && !redirect;
    pop         = instr_valid && instr_ready;
    occupancy   = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
    mem_req     = !reset && (state == RUN) && !redirect && (occupancy < DEPTH_V);
    grant       = mem_req && mem_gnt;
    push        = rspAccept && (state == RUN) && !redirect;
    outNext     = outstanding + (grant ? CNT_ONE : '0) - (rspAccept ? CNT_ONE : '0);
  end

  // Next state: a redirect with responses still in flight must swallow them before fetching again
  always_comb begin
    stateNext   = state;
    discardNext = discard;
    case (state)
      RUN: begin
        if (redirect && (outNext != '0)) begin
          stateNext   = FLUSH;
          discardNext = outNext;
        end
      end
      FLUSH: begin
        if (rspAccept) begin
          discardNext = discard - CNT_ONE;
          if (discard == CNT_ONE) begin
            stateNext = RUN;
          end
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // State, discard and outstanding-response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      discard     <= '0;
      outstanding <= '0;
    end else begin
      state       <= stateNext;
      discard     <= discardNext;
      outstanding <= outNext;
    end
  end

  // Fetch and response PCs; both restart at the redirect target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc <= RESET_PC;
      respPc  <= RESET_PC;
    end else if (redirect) begin
      fetchPc <= redirect_addr;
      respPc  <= redirect_addr;
    end else begin
      if (grant) fetchPc <= fetchPc + 16'd1;
      if (push)  respPc  <= respPc + 16'd1;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      count <= count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end
  end

  // Queue storage, registered so the head never depends combinationally on mem_rdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dataMem[i] <= '0;
        pcMem[i]   <= '0;
      end
    end else if (push) begin
      dataMem[tail] <= mem_rdata;
      pcMem[tail]   <= respPc;
    end
  end

endmodule
